// File: rtl/sram_arbiter.sv
// Three-master to one-slave arbiter for an SRAM-like bus: fixed priority
// dcache > uncached > icache, with a starvation override for icache.
module sram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  m_req,
    input  logic [2:0]  m_wr,
    input  logic [5:0]  m_size,
    input  logic [95:0] m_addr,
    input  logic [95:0] m_wdata,
    output logic [31:0] m_rdata,
    output logic [2:0]  m_addr_ok,
    output logic [2:0]  m_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [3:0]  starve_q, starve_d;
    logic [1:0]  winner;
    logic        sel_req;
    logic        sel_wr;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    assign m_rdata = s_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            grant_q  <= 2'd0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
        end
    end

    // Request/payload mux for the currently granted master.
    always_comb begin
        sel_req   = m_req[0];
        sel_wr    = m_wr[0];
        sel_size  = m_size[1:0];
        sel_addr  = m_addr[31:0];
        sel_wdata = m_wdata[31:0];
        unique case (grant_q)
            2'd1: begin
                sel_req   = m_req[1];
                sel_wr    = m_wr[1];
                sel_size  = m_size[3:2];
                sel_addr  = m_addr[63:32];
                sel_wdata = m_wdata[63:32];
            end
            2'd2: begin
                sel_req   = m_req[2];
                sel_wr    = m_wr[2];
                sel_size  = m_size[5:4];
                sel_addr  = m_addr[95:64];
                sel_wdata = m_wdata[95:64];
            end
            default: ;
        endcase
    end

    // icache jumps the queue once it has lost STARVE_LIMIT times in a row.
    always_comb begin
        winner = 2'd0;
        if (m_req[0] && (starve_q == Limit)) begin
            winner = 2'd0;
        end else if (m_req[1]) begin
            winner = 2'd1;
        end else if (m_req[2]) begin
            winner = 2'd2;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        starve_d  = starve_q;
        s_req     = 1'b0;
        s_wr      = 1'b0;
        s_size    = 2'd0;
        s_addr    = 32'd0;
        s_wdata   = 32'd0;
        m_addr_ok = 3'b000;
        m_data_ok = 3'b000;
        unique case (state_q)
            StIdle: begin
                if (|m_req) begin
                    grant_d = winner;
                    state_d = StAddr;
                    if (winner == 2'd0) begin
                        starve_d = 4'd0;
                    end else if (m_req[0] && (starve_q != Limit)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            StAddr: begin
                s_req   = 1'b1;
                s_wr    = sel_wr;
                s_size  = sel_size;
                s_addr  = sel_addr;
                s_wdata = sel_wdata;
                if (s_addr_ok) begin
                    m_addr_ok = 3'b001 << grant_q;
                    if (s_data_ok) begin
                        m_data_ok = 3'b001 << grant_q;
                        state_d   = StIdle;
                    end else begin
                        state_d = StData;
                    end
                end else if (!sel_req) begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (s_data_ok) begin
                    m_data_ok = 3'b001 << grant_q;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
